// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size/sign codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Byte-lane data-memory bus: the LSU drives ce/we/addr/wdata, the memory returns rdata and a valid pulse.
interface lsu_dmem_master_if;
    logic [31:0] daddr_o;
    logic [31:0] dwdata_o;
    logic [3:0]  we_o;
    logic        ce_o;
    logic [31:0] drdata_i;
    logic        valid_i;

    modport master (
        output daddr_o, dwdata_o, we_o, ce_o,
        input  drdata_i, valid_i
    );

    modport slave (
        input  daddr_o, dwdata_o, we_o, ce_o,
        output drdata_i, valid_i
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, load extraction/extension and legality flags.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] drdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be       = '0;
        wdata_al = '0;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be       = 4'b0001 << addr;
                wdata_al = {4{wdata[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {addr[1], 1'b0};
                wdata_al = {2{wdata[15:0]}};
                misalign = addr[0];
            end
            2'b10: begin
                be       = '1;
                wdata_al = wdata;
                misalign = (addr != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        if (we)
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    always_comb begin
        rbyte = 8'(drdata >> {addr, 3'b000});
        rhalf = 16'(drdata >> {addr[1], 4'b0000});
        case (funct3)
            F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
            F3_W:    rdata_ext = drdata;
            F3_BU:   rdata_ext = {24'd0, rbyte};
            F3_HU:   rdata_ext = {16'd0, rhalf};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit initiator: accepts one RV32I load/store, runs it on the byte-lane memory bus, returns result or error.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    lsu_dmem_master_if.master dmem
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        ce_q;
    logic [CW-1:0] wait_cnt;

    logic        idle;
    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misalign;
    logic        al_illegal;

    // One align instance: it sees the incoming request while idle, the captured request otherwise.
    assign idle      = (state == ST_IDLE);
    assign al_we     = idle ? req_we_i            : we_q;
    assign al_funct3 = idle ? req_funct3_i        : funct3_q;
    assign al_addr   = idle ? req_addr_i[1:0]     : addr_q[1:0];

    lsu_align u_align (
        .we        (al_we),
        .funct3    (al_funct3),
        .addr      (al_addr),
        .wdata     (req_wdata_i),
        .drdata    (dmem.drdata_i),
        .be        (al_be),
        .wdata_al  (al_wdata),
        .rdata_ext (al_rdata),
        .misalign  (al_misalign),
        .illegal   (al_illegal)
    );

    assign dmem.daddr_o  = addr_q;
    assign dmem.dwdata_o = wdata_q;
    assign dmem.ce_o     = ce_q;
    // Strobes only alongside valid so the memory sees a single write edge; reset suppresses a pending write.
    assign dmem.we_o     = (ce_q && we_q && dmem.valid_i && !reset) ? be_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            ce_q         <= 1'b0;
            addr_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            wait_cnt     <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        addr_q       <= req_addr_i;
                        funct3_q     <= req_funct3_i;
                        we_q         <= req_we_i;
                        wdata_q      <= al_wdata;
                        be_q         <= al_be;
                        req_ready_o  <= 1'b0;
                        resp_rdata_o <= '0;
                        wait_cnt     <= '0;
                        if (al_illegal || al_misalign) begin
                            state        <= ST_RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                        end else begin
                            state      <= ST_ACCESS;
                            ce_q       <= 1'b1;
                            resp_err_o <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dmem.valid_i) begin
                        state        <= ST_RESP;
                        ce_q         <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= we_q ? '0 : al_rdata;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        state        <= ST_RESP;
                        ce_q         <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Self-checking bench for lsu_dmem_master against a byte-array memory model and a 4-cycle valid pulse.
module tb_lsu_dmem_master;

    localparam int unsigned MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    lsu_dmem_master_if dmem ();

    lsu_dmem_master #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .dmem         (dmem)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory environment: 64 words, valid every 4th cycle, byte-lane writes.
    logic [1:0]  phase = 2'd0;
    logic        tie0 = 1'b0;
    logic        force_v = 1'b0;
    logic [31:0] mem [64];

    always @(posedge clk) phase <= phase + 2'd1;
    assign dmem.valid_i  = ((phase == 2'd3) && !tie0) || force_v;
    assign dmem.drdata_i = mem[dmem.daddr_o[7:2]];

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (dmem.we_o[i]) mem[dmem.daddr_o[7:2]][8*i +: 8] <= dmem.dwdata_o[8*i +: 8];

    // Reference model: flat byte memory with architectural RV32I semantics.
    logic [7:0] refm [256];

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = refm[a[7:0]];
        h = {refm[8'(a + 1)], refm[a[7:0]]};
        case (f3)
            3'd0: return {{24{b[7]}}, b};
            3'd4: return {24'd0, b};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'd0, h};
            default: return {refm[8'(a + 3)], refm[8'(a + 2)], h};
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] m = '0;
        for (int i = 0; i < size_of(f3); i++) m[(a % 4) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_dw(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return 32'(wd[7:0]) * 32'h0101_0101;
            2:       return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) refm[8'(a + i)] = wd[8*i +: 8];
    endtask

    // Issues one request at a negedge and observes the transaction to its response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er, output int wcnt,
                          output logic [3:0] wv, output logic [31:0] dwv, output bit coinc,
                          output bit ce_seen, output int ph);
        int n = 0;
        while (!req_ready_o && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (!req_ready_o) begin fails++; $display("FAIL ready_wait: req_ready_o=0 expected 1"); end
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
        ph = int'(phase);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = 0; rd = '0; er = 1'b0; wcnt = 0; wv = '0; dwv = '0; coinc = 1'b1; ce_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dmem.ce_o) ce_seen = 1'b1;
            if (dmem.we_o != 4'd0) begin
                wcnt++; wv = dmem.we_o; dwv = dmem.dwdata_o;
                if (!dmem.valid_i) coinc = 1'b0;
            end
            if (resp_valid_o) begin lat = k; rd = resp_rdata_o; er = resp_err_o; break; end
        end
        if (lat != 0) begin
            @(negedge clk);
            tests++;
            if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL resp_pulse_width: resp_valid_o=%b expected 0", resp_valid_o); end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({req_ready_o, resp_valid_o, resp_err_o, dmem.ce_o} !== 4'b1000) begin
            fails++; $display("FAIL reset_ctrl: ready/rv/err/ce=%b expected 1000", {req_ready_o, resp_valid_o, resp_err_o, dmem.ce_o});
        end
        tests++;
        if ({resp_rdata_o, dmem.daddr_o, dmem.dwdata_o, dmem.we_o} !== '0) begin
            fails++; $display("FAIL reset_data: rdata=%h daddr=%h dwdata=%h we=%b expected 0", resp_rdata_o, dmem.daddr_o, dmem.dwdata_o, dmem.we_o);
        end
    endtask

    task automatic test_directed;
        logic [2:0]  f3s [9] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd1, 3'd1, 3'd1, 3'd5};
        logic        wes [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ads [9] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h13, 32'h12, 32'h12, 32'h12, 32'h12};
        logic [31:0] wds [9] = '{32'hDEADBEEF, 0, 32'hA5, 0, 0, 32'h8001, 0, 0, 0};
        logic [31:0] res [9] = '{0, 32'hDEADBEEF, 0, 32'hFFFFFFA5, 32'hA5, 0, 32'hFFFF8001, 32'hFFFF8001, 32'h8001};
        logic [3:0]  wev [9] = '{4'b1111, 0, 4'b1000, 0, 0, 4'b1100, 0, 0, 0};
        logic [31:0] dwe [9] = '{32'hDEADBEEF, 0, 32'hA5A5A5A5, 0, 0, 32'h80018001, 0, 0, 0};
        int lat, wcnt, ph; logic [31:0] rd, dwv; logic er; logic [3:0] wv; bit coinc, ce_seen;
        for (int i = 0; i < 9; i++) begin
            do_req(wes[i], f3s[i], ads[i], wds[i], lat, rd, er, wcnt, wv, dwv, coinc, ce_seen, ph);
            if (wes[i]) ref_store(f3s[i], ads[i], wds[i]);
            tests++;
            if (rd !== res[i] || er !== 1'b0) begin fails++; $display("FAIL directed_%0d_resp: rdata=%h err=%b expected %h 0", i, rd, er, res[i]); end
            tests++;
            if (wcnt != (wes[i] ? 1 : 0) || !coinc) begin fails++; $display("FAIL directed_%0d_wecount: %0d writes coinc=%0d expected %0d coinc=1", i, wcnt, coinc, wes[i]); end
            if (wes[i]) begin
                tests++;
                if (wv !== wev[i] || dwv !== dwe[i]) begin fails++; $display("FAIL directed_%0d_lanes: we=%b dwdata=%h expected %b %h", i, wv, dwv, wev[i], dwe[i]); end
            end
        end
    endtask

    task automatic test_errors;
        logic        wes [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd3};
        logic [31:0] ads [3] = '{32'h11, 32'h13, 32'h10};
        int lat, wcnt, ph; logic [31:0] rd, dwv; logic er; logic [3:0] wv; bit coinc, ce_seen;
        for (int i = 0; i < 3; i++) begin
            do_req(wes[i], f3s[i], ads[i], 32'h1234_5678, lat, rd, er, wcnt, wv, dwv, coinc, ce_seen, ph);
            tests++;
            if (lat != 1 || er !== 1'b1 || rd !== 32'd0 || ce_seen || wcnt != 0) begin
                fails++; $display("FAIL error_%0d: lat=%0d err=%b rdata=%h ce=%0d writes=%0d expected 1 1 0 0 0", i, lat, er, rd, ce_seen, wcnt);
            end
        end
    endtask

    task automatic test_phases;
        int lat, wcnt, ph; logic [31:0] rd, dwv; logic er; logic [3:0] wv; bit coinc, ce_seen;
        for (int p = 0; p < 4; p++) begin
            while (int'(phase) != p) @(negedge clk);
            do_req(1'b0, 3'd2, 32'h20, 0, lat, rd, er, wcnt, wv, dwv, coinc, ce_seen, ph);
            tests++;
            if (lat != 2 + ((2 - ph) & 3) || er !== 1'b0 || rd !== exp_load(3'd2, 32'h20)) begin
                fails++; $display("FAIL phase_%0d: lat=%0d err=%b rdata=%h expected %0d 0 %h", p, lat, er, rd, 2 + ((2 - ph) & 3), exp_load(3'd2, 32'h20));
            end
        end
    endtask

    task automatic test_random;
        int lat, wcnt, ph, elat; logic [31:0] rd, dwv, a, wd, erd; logic er, we, ee; logic [2:0] f3;
        logic [3:0] wv; bit coinc, ce_seen;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
            wd = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ee = exp_err(we, f3, a);
            erd = (ee || we) ? 32'd0 : exp_load(f3, a);
            do_req(we, f3, a, wd, lat, rd, er, wcnt, wv, dwv, coinc, ce_seen, ph);
            elat = ee ? 1 : 2 + ((2 - ph) & 3);
            tests++;
            if (er !== ee || rd !== erd || lat != elat) begin
                fails++; $display("FAIL random_%0d_resp: err=%b rdata=%h lat=%0d expected %b %h %0d", n, er, rd, lat, ee, erd, elat);
            end
            tests++;
            if (wcnt != ((we && !ee) ? 1 : 0) || !coinc) begin
                fails++; $display("FAIL random_%0d_wecount: %0d writes coinc=%0d expected %0d", n, wcnt, coinc, we && !ee);
            end
            if (we && !ee) begin
                tests++;
                if (wv !== exp_be(f3, a) || dwv !== exp_dw(f3, wd)) begin
                    fails++; $display("FAIL random_%0d_lanes: we=%b dwdata=%h expected %b %h", n, wv, dwv, exp_be(f3, a), exp_dw(f3, wd));
                end
                ref_store(f3, a, wd);
            end
        end
    endtask

    task automatic test_timeout;
        int lat, wcnt, ph; logic [31:0] rd, dwv; logic er; logic [3:0] wv; bit coinc, ce_seen;
        tie0 = 1'b1;
        do_req(1'b1, 3'd2, 32'h24, 32'hCAFEF00D, lat, rd, er, wcnt, wv, dwv, coinc, ce_seen, ph);
        tie0 = 1'b0;
        tests++;
        if (lat != MAX_WAIT + 1 || er !== 1'b1 || rd !== 32'd0 || wcnt != 0) begin
            fails++; $display("FAIL timeout: lat=%0d err=%b rdata=%h writes=%0d expected %0d 1 0 0", lat, er, rd, wcnt, MAX_WAIT + 1);
        end
        do_req(1'b0, 3'd2, 32'h24, 0, lat, rd, er, wcnt, wv, dwv, coinc, ce_seen, ph);
        tests++;
        if (rd !== exp_load(3'd2, 32'h24) || er !== 1'b0) begin
            fails++; $display("FAIL timeout_mem: rdata=%h err=%b expected %h 0", rd, er, exp_load(3'd2, 32'h24));
        end
    endtask

    task automatic test_reset_mid;
        int lat, wcnt, ph; logic [31:0] rd, dwv; logic er; logic [3:0] wv; bit coinc, ce_seen;
        bit pulse = 1'b0;
        tie0 = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd2; req_addr_i = 32'h28; req_wdata_i = 32'h5555AAAA;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (dmem.ce_o !== 1'b1) begin fails++; $display("FAIL midreset_access: ce_o=%b expected 1", dmem.ce_o); end
        reset = 1'b1; force_v = 1'b1;
        #1;
        tests++;
        if (dmem.we_o !== 4'd0) begin fails++; $display("FAIL midreset_we: we_o=%b expected 0000", dmem.we_o); end
        @(negedge clk);
        reset = 1'b0; force_v = 1'b0; tie0 = 1'b0;
        tests++;
        if (dmem.ce_o !== 1'b0 || req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            fails++; $display("FAIL midreset_state: ce=%b ready=%b rv=%b expected 0 1 0", dmem.ce_o, req_ready_o, resp_valid_o);
        end
        repeat (6) begin @(negedge clk); if (resp_valid_o) pulse = 1'b1; end
        tests++;
        if (pulse) begin fails++; $display("FAIL midreset_nopulse: resp_valid_o seen 1 expected 0"); end
        do_req(1'b0, 3'd2, 32'h28, 0, lat, rd, er, wcnt, wv, dwv, coinc, ce_seen, ph);
        tests++;
        if (rd !== exp_load(3'd2, 32'h28) || er !== 1'b0) begin
            fails++; $display("FAIL midreset_mem: rdata=%h err=%b expected %h 0", rd, er, exp_load(3'd2, 32'h28));
        end
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0; req_addr_i = '0; req_wdata_i = '0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) refm[4*i + b] = w[8*b +: 8];
        end
        @(negedge clk);
        test_reset;
        test_directed;
        test_errors;
        test_phases;
        test_random;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000 expected finish");
        $fatal(1);
    end

endmodule
